// File: rtl/apb_vga_ctrl_regs_if.sv
// APB3 completer-side bus bundle for the VGA control register block.
// Latency: wires only, no storage.
// Backpressure: none; the completer ties PREADY high.
interface apb_vga_ctrl_regs_if;
  logic        PSEL;
  logic [11:2] PADDR;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_vga_ctrl_regs.sv
// VGA control registers: shadowed CTRL/BASE committed at frame boundaries, vsync irq, frame counter.
// Latency: reads are combinational in the access phase; writes commit on the edge ending it.
// Backpressure: none, PREADY tied high (zero wait states).
module apb_vga_ctrl_regs #(
  parameter int          NCH    = 2,
  parameter int          FCNT_W = 16,
  parameter logic [27:0] ID_VAL = 28'h0A6C001
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  apb_vga_ctrl_regs_if.slave    apb,
  input  logic [3:0]            ECOREVNUM,
  input  logic                  frame_start,
  output logic                  vga_en,
  output logic [NCH-1:0]        layer_en,
  output logic [31:0]           fb_base,
  output logic                  irq
);

  localparam logic [9:0] A_CTRL   = 10'd0;
  localparam logic [9:0] A_BASE   = 10'd1;
  localparam logic [9:0] A_STATUS = 10'd2;
  localparam logic [9:0] A_IRQEN  = 10'd3;
  localparam logic [9:0] A_FCNT   = 10'd4;
  localparam logic [9:0] A_ID     = 10'd5;

  // Shadow copies (software view) and active copies (display view)
  logic              sh_en;
  logic [NCH-1:0]    sh_layer;
  logic [31:2]       sh_base;
  logic              commit_pend;
  logic [31:2]       act_base;
  logic              vsync_pend;
  logic              irq_en;
  logic [FCNT_W-1:0] fcnt;

  logic access;
  logic addr_valid;
  logic addr_ro;
  logic bad_access;
  logic wr_ok;
  logic wr_ctrl;
  logic wr_base;
  logic wr_status;
  logic wr_irqen;
  logic commit;
  logic frame_tick;

  assign access     = apb.PSEL & apb.PENABLE;
  assign addr_valid = (apb.PADDR <= A_ID);
  assign addr_ro    = (apb.PADDR == A_FCNT) | (apb.PADDR == A_ID);
  // Out-of-map accesses and writes to read-only registers error out and change nothing
  assign bad_access = access & (~addr_valid | (apb.PWRITE & addr_ro));
  assign wr_ok      = access & apb.PWRITE & ~bad_access;
  assign wr_ctrl    = wr_ok & (apb.PADDR == A_CTRL);
  assign wr_base    = wr_ok & (apb.PADDR == A_BASE);
  assign wr_status  = wr_ok & (apb.PADDR == A_STATUS);
  assign wr_irqen   = wr_ok & (apb.PADDR == A_IRQEN);

  // With the display off there is no frame boundary to wait for, so commit on the next edge
  assign commit     = commit_pend & (frame_start | ~vga_en);
  // Frames only count while the active display is enabled
  assign frame_tick = frame_start & vga_en;

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = bad_access;
  assign fb_base     = {act_base, 2'b00};
  // Both operands are flops, so irq has no path from the APB inputs
  assign irq         = vsync_pend & irq_en;

  // Read mux; idle bus and writes return zero
  always_comb begin
    apb.PRDATA = '0;
    if (access && !apb.PWRITE) begin
      case (apb.PADDR)
        A_CTRL:   apb.PRDATA = {{(31-NCH){1'b0}}, sh_layer, sh_en};
        A_BASE:   apb.PRDATA = {sh_base, 2'b00};
        A_STATUS: apb.PRDATA = {30'd0, commit_pend, vsync_pend};
        A_IRQEN:  apb.PRDATA = {31'd0, irq_en};
        A_FCNT:   apb.PRDATA = 32'(fcnt);
        A_ID:     apb.PRDATA = {ECOREVNUM, ID_VAL};
        default:  apb.PRDATA = '0;
      endcase
    end
  end

  // Shadow registers and commit-pending flag; a write on a commit edge re-arms the flag
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sh_en       <= 1'b0;
      sh_layer    <= '0;
      sh_base     <= '0;
      commit_pend <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        sh_en    <= apb.PWDATA[0];
        sh_layer <= apb.PWDATA[NCH:1];
      end
      if (wr_base)
        sh_base <= apb.PWDATA[31:2];
      if (wr_ctrl || wr_base)
        commit_pend <= 1'b1;
      else if (commit)
        commit_pend <= 1'b0;
    end
  end

  // Active outputs load the pre-edge shadow values on a commit
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      vga_en   <= 1'b0;
      layer_en <= '0;
      act_base <= '0;
    end else if (commit) begin
      vga_en   <= sh_en;
      layer_en <= sh_layer;
      act_base <= sh_base;
    end
  end

  // Frame counter and vsync status; a new frame beats a simultaneous W1C
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      fcnt       <= '0;
      vsync_pend <= 1'b0;
    end else begin
      if (frame_tick)
        fcnt <= fcnt + FCNT_W'(1);
      if (frame_tick)
        vsync_pend <= 1'b1;
      else if (wr_status && apb.PWDATA[0])
        vsync_pend <= 1'b0;
    end
  end

  // Interrupt enable
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)
      irq_en <= 1'b0;
    else if (wr_irqen)
      irq_en <= apb.PWDATA[0];
  end

endmodule

// File: tb/tb_apb_vga_ctrl_regs.sv
// Randomized scoreboard bench for apb_vga_ctrl_regs against a frame-level reference model.
// Latency: expectations are queued at issue time and checked on the falling edge.
// Backpressure: DUT never stalls; the driver issues back-to-back APB transfers.
module tb_apb_vga_ctrl_regs;
  localparam int          NCH    = 2;
  localparam int          FCNT_W = 4;
  localparam logic [27:0] ID_VAL = 28'h0A6C001;
  localparam logic [3:0]  ECO    = 4'h5;

  typedef struct packed {
    logic        en;
    logic [1:0]  layer;
    logic [31:0] base;
    logic        irq;
  } out_t;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rd_t;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [3:0]  ECOREVNUM;
  logic        frame_start;
  logic        vga_en;
  logic [NCH-1:0] layer_en;
  logic [31:0] fb_base;
  logic        irq;

  apb_vga_ctrl_regs_if apb_if();

  apb_vga_ctrl_regs #(.NCH(NCH), .FCNT_W(FCNT_W), .ID_VAL(ID_VAL)) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .apb         (apb_if),
    .ECOREVNUM   (ECOREVNUM),
    .frame_start (frame_start),
    .vga_en      (vga_en),
    .layer_en    (layer_en),
    .fb_base     (fb_base),
    .irq         (irq)
  );

  always #5 PCLK = ~PCLK;

  int errors = 0;
  int checks = 0;

  out_t out_q[$];
  rd_t  rd_q[$];

  // Reference model: software-visible state in plain variables
  logic [2:0]  m_sctrl;
  logic [31:0] m_sbase;
  bit          m_pend;
  bit          m_en;
  logic [1:0]  m_layer;
  logic [31:0] m_base;
  bit          m_vp;
  bit          m_irqen;
  int          m_fcnt;

  function automatic rd_t exp_rd(input int idx, input bit wr);
    rd_t r;
    r.err  = (idx > 5) || (wr && (idx == 4 || idx == 5));
    r.data = 32'd0;
    if (!wr) begin
      case (idx)
        0: r.data = {29'd0, m_sctrl};
        1: r.data = m_sbase;
        2: r.data = {30'd0, m_pend, m_vp};
        3: r.data = {31'd0, m_irqen};
        4: r.data = 32'(m_fcnt);
        5: r.data = {ECO, ID_VAL};
        default: r.data = 32'd0;
      endcase
    end
    return r;
  endfunction

  // Advance the model by one clock and queue the outputs it predicts afterwards
  always @(posedge PCLK) begin
    out_t o;
    if (!PRESETn) begin
      m_sctrl = 0; m_sbase = 0; m_pend = 0; m_en = 0; m_layer = 0;
      m_base = 0; m_vp = 0; m_irqen = 0; m_fcnt = 0;
    end else begin
      bit acc, w, tick, com;
      int idx;
      acc  = apb_if.PSEL && apb_if.PENABLE;
      w    = acc && apb_if.PWRITE;
      idx  = int'(apb_if.PADDR);
      tick = frame_start && m_en;
      com  = m_pend && (frame_start || !m_en);
      if (tick) begin
        m_fcnt = (m_fcnt + 1) % (1 << FCNT_W);
      end
      if (com) begin
        m_en    = m_sctrl[0];
        m_layer = m_sctrl[2:1];
        m_base  = m_sbase;
        m_pend  = 0;
      end
      if (w && idx == 0) begin
        m_sctrl = apb_if.PWDATA[2:0];
        m_pend  = 1;
      end
      if (w && idx == 1) begin
        m_sbase = apb_if.PWDATA & 32'hFFFF_FFFC;
        m_pend  = 1;
      end
      if (w && idx == 2 && apb_if.PWDATA[0]) m_vp = 0;
      if (tick) m_vp = 1;
      if (w && idx == 3) m_irqen = apb_if.PWDATA[0];
    end
    o.en    = m_en;
    o.layer = m_layer;
    o.base  = m_base;
    o.irq   = m_vp && m_irqen;
    out_q.push_back(o);
  end

  // Monitor: compare DUT outputs against queued expectations away from the rising edge
  always @(negedge PCLK) begin
    out_t e;
    rd_t  r;
    if (!PRESETn) begin
      if (out_q.size() > 0) void'(out_q.pop_front());
      checks++;
      if (vga_en !== 1'b0 || layer_en !== '0 || fb_base !== 32'd0 || irq !== 1'b0 ||
          apb_if.PRDATA !== 32'd0 || apb_if.PSLVERR !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: got en=%b layer=%b base=%h irq=%b prdata=%h slverr=%b, want all 0",
                 vga_en, layer_en, fb_base, irq, apb_if.PRDATA, apb_if.PSLVERR);
      end
    end else begin
      if (out_q.size() > 0) begin
        e = out_q.pop_front();
        checks++;
        if (vga_en !== e.en || layer_en !== e.layer || fb_base !== e.base || irq !== e.irq) begin
          errors++;
          $display("FAIL active_outputs @%0t: got en=%b layer=%b base=%h irq=%b, want en=%b layer=%b base=%h irq=%b",
                   $time, vga_en, layer_en, fb_base, irq, e.en, e.layer, e.base, e.irq);
        end
      end
      checks++;
      if (apb_if.PSEL && apb_if.PENABLE) begin
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL apb_access @%0t: access with no expectation queued", $time);
        end else begin
          r = rd_q.pop_front();
          if (apb_if.PRDATA !== r.data || apb_if.PSLVERR !== r.err || apb_if.PREADY !== 1'b1) begin
            errors++;
            $display("FAIL apb_resp @%0t addr=%h: got prdata=%h slverr=%b ready=%b, want prdata=%h slverr=%b ready=1",
                     $time, apb_if.PADDR, apb_if.PRDATA, apb_if.PSLVERR, apb_if.PREADY, r.data, r.err);
          end
        end
      end else if (apb_if.PRDATA !== 32'd0 || apb_if.PSLVERR !== 1'b0) begin
        errors++;
        $display("FAIL apb_idle @%0t: got prdata=%h slverr=%b, want 0 and 0",
                 $time, apb_if.PRDATA, apb_if.PSLVERR);
      end
    end
  end

  // One APB transfer; entered and left at 1 time unit after a rising edge
  task automatic apb_xfer(input bit wr, input int idx, input logic [31:0] d,
                          input bit fs_setup, input bit fs_access);
    apb_if.PSEL    = 1'b1;
    apb_if.PENABLE = 1'b0;
    apb_if.PWRITE  = wr;
    apb_if.PADDR   = 10'(idx);
    apb_if.PWDATA  = d;
    frame_start    = fs_setup;
    @(posedge PCLK); #1;
    apb_if.PENABLE = 1'b1;
    frame_start    = fs_access;
    rd_q.push_back(exp_rd(idx, wr));
    @(posedge PCLK); #1;
    apb_if.PSEL    = 1'b0;
    apb_if.PENABLE = 1'b0;
    apb_if.PWRITE  = 1'b0;
    frame_start    = 1'b0;
  endtask

  task automatic idle(input int n, input bit fs);
    frame_start = fs;
    repeat (n) begin
      @(posedge PCLK); #1;
    end
    frame_start = 1'b0;
  endtask

  task automatic rd(input int idx);
    apb_xfer(1'b0, idx, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    apb_xfer(1'b1, idx, d, 1'b0, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    PRESETn        = 1'b0;
    ECOREVNUM      = ECO;
    frame_start    = 1'b0;
    apb_if.PSEL    = 1'b0;
    apb_if.PENABLE = 1'b0;
    apb_if.PWRITE  = 1'b0;
    apb_if.PADDR   = '0;
    apb_if.PWDATA  = '0;
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;

    // Reset values of the whole map plus one undefined offset
    for (int i = 0; i <= 6; i++) rd(i);

    // Display off: commit lands one edge after the write
    wr(0, 32'h7);
    rd(2);
    rd(0);

    // Display on: BASE waits for a frame boundary
    wr(1, 32'h1000_0003);
    rd(1);
    idle(3, 1'b0);
    idle(1, 1'b1);
    rd(2);

    // Interrupt, consecutive frames, W1C and W1C racing a frame
    wr(3, 32'h1);
    idle(3, 1'b1);
    rd(4);
    wr(2, 32'h1);
    rd(2);
    idle(1, 1'b1);
    apb_xfer(1'b1, 2, 32'h1, 1'b0, 1'b1);
    rd(2);

    // Counter wrap and read-only write rejection
    idle(17, 1'b1);
    rd(4);
    wr(4, 32'hFFFF_FFFF);
    rd(4);
    wr(5, 32'h0);
    apb_xfer(1'b1, 16, 32'h3, 1'b0, 1'b0);
    rd(16);
    rd(1023);

    // CTRL write on the same edge as a frame: old shadow applies, new one next frame
    apb_xfer(1'b1, 0, 32'h3, 1'b0, 1'b1);
    rd(2);
    idle(2, 1'b0);
    idle(1, 1'b1);
    rd(2);

    // Reset in the middle of a pending commit
    wr(0, 32'h5);
    PRESETn = 1'b0;
    idle(3, 1'b1);
    PRESETn = 1'b1;
    for (int i = 0; i <= 5; i++) rd(i);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      int  op;
      int  idx;
      logic [31:0] d;
      op  = int'($urandom_range(0, 9));
      idx = ($urandom_range(0, 15) == 0) ? int'($urandom_range(6, 1023)) : int'($urandom_range(0, 5));
      d   = $urandom;
      if (idx == 0 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      if (op < 2) begin
        idle(int'($urandom_range(1, 3)), ($urandom_range(0, 1) == 1));
      end else begin
        apb_xfer(op >= 6, idx, d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      end
    end

    idle(3, 1'b0);
    checks++;
    if (rd_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d APB expectations left, want 0", rd_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
